// File: rtl/bram_arbiter_if.sv
// Requester and RAM-side signals of the two-port BRAM arbiter.
// slave is the arbiter's view; master is the view of the requesters plus RAM.
interface bram_arbiter_if #(
  parameter int unsigned ADDR_WIDTH = 14
);
  logic                  m0_req;
  logic [3:0]            m0_we;
  logic [ADDR_WIDTH-1:0] m0_addr;
  logic [31:0]           m0_wdata;
  logic                  m0_gnt;
  logic                  m0_rvalid;
  logic [31:0]           m0_rdata;

  logic                  m1_req;
  logic [3:0]            m1_we;
  logic [ADDR_WIDTH-1:0] m1_addr;
  logic [31:0]           m1_wdata;
  logic                  m1_gnt;
  logic                  m1_rvalid;
  logic [31:0]           m1_rdata;

  logic [ADDR_WIDTH-1:0] ram_addra;
  logic [31:0]           ram_dina;
  logic [3:0]            ram_wea;
  logic [ADDR_WIDTH-1:0] ram_addrb;
  logic [31:0]           ram_doutb;

  logic                  init_done;

  modport slave (
    input  m0_req, m0_we, m0_addr, m0_wdata,
    input  m1_req, m1_we, m1_addr, m1_wdata,
    input  ram_doutb,
    output m0_gnt, m0_rvalid, m0_rdata,
    output m1_gnt, m1_rvalid, m1_rdata,
    output ram_addra, ram_dina, ram_wea, ram_addrb,
    output init_done
  );

  modport master (
    output m0_req, m0_we, m0_addr, m0_wdata,
    output m1_req, m1_we, m1_addr, m1_wdata,
    output ram_doutb,
    input  m0_gnt, m0_rvalid, m0_rdata,
    input  m1_gnt, m1_rvalid, m1_rdata,
    input  ram_addra, ram_dina, ram_wea, ram_addrb,
    input  init_done
  );
endinterface

// File: rtl/bram_arbiter.sv
// Round-robin arbiter sharing a simple dual-port BRAM between two requesters,
// with an optional zero-fill of the whole RAM after reset.
module bram_arbiter #(
  parameter int unsigned ADDR_WIDTH     = 14,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input logic           clk,
  input logic           rst_n,
  bram_arbiter_if.slave bus
);

  typedef enum logic [0:0] {StClear, StRun} state_e;

  state_e                state_q;
  logic [ADDR_WIDTH:0]   clr_cnt_q;  // MSB set once the last clear write is issued
  logic                  prio_q;     // 1: m1 wins a tie
  logic [1:0]            rv_q;
  logic [1:0]            own_q;
  logic [3:0]            wea_q;
  logic [ADDR_WIDTH-1:0] addra_q;
  logic [ADDR_WIDTH-1:0] addrb_q;
  logic [31:0]           dina_q;
  logic                  init_done_q;

  logic                  run;
  logic                  gnt0;
  logic                  gnt1;
  logic                  acc;
  logic                  sel;
  logic [3:0]            acc_we;
  logic [ADDR_WIDTH-1:0] acc_addr;
  logic [31:0]           acc_wdata;

  always_comb begin
    run       = (state_q == StRun);
    gnt0      = run & bus.m0_req & (~bus.m1_req | ~prio_q);
    gnt1      = run & bus.m1_req & (~bus.m0_req | prio_q);
    acc       = gnt0 | gnt1;
    sel       = gnt1;
    acc_we    = sel ? bus.m1_we    : bus.m0_we;
    acc_addr  = sel ? bus.m1_addr  : bus.m0_addr;
    acc_wdata = sel ? bus.m1_wdata : bus.m0_wdata;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= CLEAR_ON_RESET ? StClear : StRun;
      clr_cnt_q   <= '0;
      prio_q      <= 1'b0;
      rv_q        <= '0;
      own_q       <= '0;
      wea_q       <= 4'h0;
      addra_q     <= '0;
      addrb_q     <= '0;
      dina_q      <= '0;
      init_done_q <= 1'b0;
    end else begin
      rv_q  <= {rv_q[0], acc & (acc_we == 4'h0)};
      own_q <= {own_q[0], sel};
      unique case (state_q)
        StClear: begin
          if (clr_cnt_q[ADDR_WIDTH]) begin
            state_q     <= StRun;
            init_done_q <= 1'b1;
            wea_q       <= 4'h0;
          end else begin
            wea_q     <= 4'hF;
            addra_q   <= clr_cnt_q[ADDR_WIDTH-1:0];
            dina_q    <= '0;
            clr_cnt_q <= clr_cnt_q + {{ADDR_WIDTH{1'b0}}, 1'b1};
          end
        end
        StRun: begin
          init_done_q <= 1'b1;
          wea_q       <= 4'h0;
          if (acc) begin
            prio_q <= gnt0;
            if (acc_we != 4'h0) begin
              wea_q   <= acc_we;
              addra_q <= acc_addr;
              dina_q  <= acc_wdata;
            end else begin
              addrb_q <= acc_addr;
            end
          end
        end
      endcase
    end
  end

  // Both requesters see the RAM output; rvalid alone tells them whose it is.
  assign bus.m0_gnt    = gnt0;
  assign bus.m1_gnt    = gnt1;
  assign bus.m0_rvalid = rv_q[1] & ~own_q[1];
  assign bus.m1_rvalid = rv_q[1] &  own_q[1];
  assign bus.m0_rdata  = bus.ram_doutb;
  assign bus.m1_rdata  = bus.ram_doutb;
  assign bus.ram_addra = addra_q;
  assign bus.ram_dina  = dina_q;
  assign bus.ram_wea   = wea_q;
  assign bus.ram_addrb = addrb_q;
  assign bus.init_done = init_done_q;

endmodule

// File: tb/tb_bram_arbiter.sv
// Randomized scoreboard bench for bram_arbiter (ADDR_WIDTH=4, clear enabled),
// with a behavioural RAM and a word-array reference model.
module tb_bram_arbiter;

  typedef struct packed {
    logic        req;
    logic [3:0]  we;
    logic [3:0]  addr;
    logic [31:0] data;
  } rq_t;

  typedef struct {
    logic        owner;
    logic [31:0] data;
    int          due;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc_n = 0;
  int   n_cmp = 0;
  int   n_fail = 0;

  bram_arbiter_if #(.ADDR_WIDTH(4)) bus ();

  bram_arbiter #(
    .ADDR_WIDTH    (4),
    .CLEAR_ON_RESET(1'b1)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  // Behavioural simple dual-port RAM: byte-write port A, registered read port B.
  logic [31:0] ram [16];
  always @(posedge clk) begin
    for (int b = 0; b < 4; b++)
      if (bus.ram_wea[b]) ram[bus.ram_addra][b*8 +: 8] <= bus.ram_dina[b*8 +: 8];
    bus.ram_doutb <= ram[bus.ram_addrb];
  end

  // Reference model state.
  logic [31:0] mem_m [16];
  logic        last_gnt;   // requester granted most recently (1 = m1)
  logic [3:0]  exp_addrb;
  exp_t        sb [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc_n);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) mem_m[i] = 32'h0;
    last_gnt  = 1'b1;
    exp_addrb = 4'h0;
    sb.delete();
  endtask

  // Response monitor: pops one expectation per rvalid pulse.
  always @(negedge clk) begin
    if (bus.m0_rvalid || bus.m1_rvalid) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_rvalid: got m0=%b m1=%b expected none (cycle %0d)",
                 bus.m0_rvalid, bus.m1_rvalid, cyc_n);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("rvalid_owner", {30'h0, bus.m1_rvalid, bus.m0_rvalid}, e.owner ? 32'h2 : 32'h1);
        chk("rdata", e.owner ? bus.m1_rdata : bus.m0_rdata, e.data);
        chk("rvalid_cycle", cyc_n, e.due);
      end
    end
  end

  // Called at posedge+1: drive both requesters, check grants mid-cycle,
  // then check the registered RAM-side outputs after the edge.
  task automatic cyc(input rq_t r0, input rq_t r1, output logic g0, output logic g1);
    rq_t  a;
    logic wr;
    bus.m0_req = r0.req; bus.m0_we = r0.we; bus.m0_addr = r0.addr; bus.m0_wdata = r0.data;
    bus.m1_req = r1.req; bus.m1_we = r1.we; bus.m1_addr = r1.addr; bus.m1_wdata = r1.data;
    @(negedge clk);
    if (r0.req && r1.req) begin
      g0 = (last_gnt == 1'b1);
      g1 = ~g0;
    end else begin
      g0 = r0.req;
      g1 = r1.req;
    end
    chk("m0_gnt", bus.m0_gnt, g0);
    chk("m1_gnt", bus.m1_gnt, g1);
    a  = g1 ? r1 : r0;
    wr = (g0 | g1) && (a.we != 4'h0);
    if (g0 | g1) begin
      last_gnt = g1;
      if (a.we == 4'h0) begin
        sb.push_back('{owner: g1, data: mem_m[a.addr], due: cyc_n + 2});
        exp_addrb = a.addr;
      end else begin
        for (int b = 0; b < 4; b++)
          if (a.we[b]) mem_m[a.addr][b*8 +: 8] = a.data[b*8 +: 8];
      end
    end
    @(posedge clk);
    #1;
    chk("ram_wea", bus.ram_wea, wr ? a.we : 4'h0);
    if (wr) begin
      chk("ram_addra", bus.ram_addra, a.addr);
      chk("ram_dina", bus.ram_dina, a.data);
    end
    chk("ram_addrb", bus.ram_addrb, exp_addrb);
  endtask

  task automatic check_reset_vals();
    chk("rst_wea", bus.ram_wea, 4'h0);
    chk("rst_addra", bus.ram_addra, 4'h0);
    chk("rst_addrb", bus.ram_addrb, 4'h0);
    chk("rst_dina", bus.ram_dina, 32'h0);
    chk("rst_init_done", bus.init_done, 1'b0);
    chk("rst_rvalid", {bus.m1_rvalid, bus.m0_rvalid}, 2'b00);
  endtask

  // Called at posedge+1 right after reset release; requests are held high throughout.
  task automatic check_clear(input int n);
    bus.m0_req = 1'b1; bus.m0_we = 4'h0; bus.m0_addr = 4'h0;
    bus.m1_req = 1'b1; bus.m1_we = 4'h0; bus.m1_addr = 4'h0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      chk("clr_wea", bus.ram_wea, 4'hF);
      chk("clr_addra", bus.ram_addra, i);
      chk("clr_dina", bus.ram_dina, 32'h0);
      chk("clr_init_done", bus.init_done, 1'b0);
      chk("clr_gnt", {bus.m1_gnt, bus.m0_gnt}, 2'b00);
    end
  endtask

  task automatic finish_clear();
    bus.m0_req = 1'b0;
    bus.m1_req = 1'b0;
    @(posedge clk);
    #1;
    chk("done_init_done", bus.init_done, 1'b1);
    chk("done_wea", bus.ram_wea, 4'h0);
    model_reset();
  endtask

  task automatic do_reset(input int cycles);
    rst_n = 1'b0;
    repeat (cycles) @(posedge clk);
    #1;
    check_reset_vals();
    rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rq_t  idle, p0, p1;
    logic g0, g1;
    logic pend0, pend1;

    idle = '0;
    bus.m0_req = 1'b0; bus.m0_we = 4'h0; bus.m0_addr = 4'h0; bus.m0_wdata = 32'h0;
    bus.m1_req = 1'b0; bus.m1_we = 4'h0; bus.m1_addr = 4'h0; bus.m1_wdata = 32'h0;
    model_reset();

    // Reset, partial clear, reset again mid-clear, then a full clear.
    do_reset(3);
    check_clear(5);
    do_reset(2);
    check_clear(16);
    finish_clear();

    // Both requesters for 4 cycles from the reset pointer: m0, m1, m0, m1.
    for (int i = 0; i < 4; i++) begin
      cyc('{1'b1, 4'h0, 4'h0, 32'h0}, '{1'b1, 4'h0, 4'h0, 32'h0}, g0, g1);
      chk("alt_m0", g0, (i % 2) == 0);
    end

    // Write then read back on m0.
    cyc('{1'b1, 4'hF, 4'd3, 32'hDEADBEEF}, idle, g0, g1);
    cyc('{1'b1, 4'h0, 4'd3, 32'h0}, idle, g0, g1);
    repeat (3) cyc(idle, idle, g0, g1);

    // Partial-byte write on m1, then read back.
    cyc(idle, '{1'b1, 4'b0010, 4'd5, 32'h0000AB00}, g0, g1);
    cyc(idle, '{1'b1, 4'h0, 4'd5, 32'h0}, g0, g1);
    repeat (3) cyc(idle, idle, g0, g1);

    // Interleaved back-to-back reads.
    cyc('{1'b1, 4'hF, 4'd1, 32'h11111111}, idle, g0, g1);
    cyc(idle, '{1'b1, 4'hF, 4'd2, 32'h22222222}, g0, g1);
    cyc('{1'b1, 4'h0, 4'd1, 32'h0}, idle, g0, g1);
    cyc(idle, '{1'b1, 4'h0, 4'd2, 32'h0}, g0, g1);
    cyc('{1'b1, 4'h0, 4'd1, 32'h0}, idle, g0, g1);
    repeat (3) cyc(idle, idle, g0, g1);

    // Random traffic; an ungranted request is held unchanged until granted.
    pend0 = 1'b0;
    pend1 = 1'b0;
    p0 = idle;
    p1 = idle;
    for (int i = 0; i < 300; i++) begin
      if (!pend0) begin
        pend0 = ($urandom_range(0, 2) != 0);
        p0 = '{pend0, ($urandom_range(0, 1) != 0) ? 4'h0 : 4'($urandom_range(1, 15)),
               4'($urandom_range(0, 15)), $urandom};
      end
      if (!pend1) begin
        pend1 = ($urandom_range(0, 2) != 0);
        p1 = '{pend1, ($urandom_range(0, 1) != 0) ? 4'h0 : 4'($urandom_range(1, 15)),
               4'($urandom_range(0, 15)), $urandom};
      end
      cyc(p0, p1, g0, g1);
      if (g0) pend0 = 1'b0;
      if (g1) pend1 = 1'b0;
    end
    repeat (3) cyc(idle, idle, g0, g1);

    // Reset one cycle after a read grant: the read is dropped and the clear restarts.
    cyc('{1'b1, 4'h0, 4'd2, 32'h0}, idle, g0, g1);
    sb.delete();
    do_reset(2);
    check_clear(16);
    finish_clear();
    repeat (4) cyc(idle, idle, g0, g1);

    chk("scoreboard_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/bram_arbiter.md
BRAM_ARBITER -- requirements
Module: bram_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 14, the word-address width of the attached RAM.
REQ-002 SHALL have parameter CLEAR_ON_RESET, default 1; 1 means zero-fill the RAM after reset, 0 means skip the fill.
REQ-003 clk  input  1  single clock for all logic; rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 m0_req / m1_req  input  1  requester n presents an access.
REQ-006 m0_we / m1_we  input  4  byte write enables; 4'b0000 means a read.
REQ-007 m0_addr / m1_addr  input  ADDR_WIDTH  word address.
REQ-008 m0_wdata / m1_wdata  input  32  write data.
REQ-009 m0_gnt / m1_gnt  output  1  access accepted this cycle.
REQ-010 m0_rvalid / m1_rvalid  output  1  read data valid, one-cycle pulse.
REQ-011 m0_rdata / m1_rdata  output  32  read data; both are driven from ram_doutb.
REQ-012 ram_addra  output  ADDR_WIDTH  RAM write address.
REQ-013 ram_dina  output  32  RAM write data.
REQ-014 ram_wea  output  4  RAM byte write enables.
REQ-015 ram_addrb  output  ADDR_WIDTH  RAM read address.
REQ-016 ram_doutb  input  32  RAM registered read data (one-cycle RAM latency).
REQ-017 init_done  output  1  high once the clear is complete; stays high until reset.

Function
REQ-018 SHALL implement FSM states CLEAR and RUN; reset enters CLEAR if CLEAR_ON_RESET=1, else RUN.
REQ-019 CLEAR SHALL write 32'h0 with ram_wea=4'hF to addresses 0, 1, ... 2**ADDR_WIDTH-1, one per cycle.
REQ-020 CLEAR SHALL enter RUN in the cycle after the write to the last address is issued.
REQ-021 init_done SHALL assert on the first RUN cycle.
REQ-022 In CLEAR, m0_gnt and m1_gnt SHALL be 0 regardless of requests.
REQ-023 In RUN, at most one of m0_gnt/m1_gnt SHALL be asserted per cycle.
REQ-024 gnt SHALL be combinational from req and the round-robin pointer; a request is accepted in the cycle req=1 and gnt=1.
REQ-025 With a single requester active, that requester SHALL be granted every cycle.
REQ-026 On simultaneous requests, the requester not granted most recently SHALL win.
REQ-027 The round-robin pointer SHALL reset to "m0 has priority" and update only on a grant.
REQ-028 An accepted write SHALL drive ram_addra/ram_dina/ram_wea from registers on the next cycle.
REQ-029 ram_wea SHALL be 4'h0 in every cycle that does not carry an accepted write or a clear write.
REQ-030 An accepted read SHALL register its address into ram_addrb on the next cycle.
REQ-031 For an accepted read, the matching mN_rvalid SHALL pulse exactly 2 cycles after the grant cycle, carrying ram_doutb.
REQ-032 A 2-stage valid/owner pipeline SHALL route each rvalid to the requester that issued the read.
REQ-033 ram_addrb SHALL hold its last value when no read is accepted.
REQ-034 A read granted in the cycle after a write to the same address SHALL return the new data; no forwarding logic is required, because write commit precedes the read sample.
REQ-035 Back-to-back reads SHALL sustain one rvalid per cycle, with ordering preserved.
REQ-036 Requesters SHALL hold req/we/addr/wdata stable until granted; the arbiter does not latch ungranted requests.

Reset
REQ-037 rst_n=0 at a clk edge SHALL clear: the pointer, rvalid pipeline, ram_wea=0, ram_addra=0, ram_addrb=0, ram_dina=0, the clear counter, and init_done=0.
REQ-038 Reset asserted mid-CLEAR SHALL restart the clear from address 0.
REQ-039 Reset asserted mid-RUN SHALL drop in-flight reads, with no rvalid after release.

Verification
REQ-040 ADDR_WIDTH=4, CLEAR_ON_RESET=1, release reset -> 16 cycles of ram_wea=F with addra 0..15 and dina=0, then init_done=1 on the next cycle; gnt=0 throughout CLEAR.
REQ-041 m0 writes 32'hDEADBEEF, we=4'hF, to addr 3; next cycle m0 reads addr 3 -> m0_rvalid 2 cycles after the read grant, with m0_rdata=DEADBEEF.
REQ-042 m0 and m1 both hold req=1 for 4 cycles -> grants alternate m0, m1, m0, m1 (from the reset pointer).
REQ-043 m1 write we=4'b0010, data 32'h0000AB00, to a zeroed addr 5, then m1 reads addr 5 -> m1_rdata=32'h0000AB00; m0_rvalid stays 0.
REQ-044 Interleaved reads: m0 addr 1, m1 addr 2, m0 addr 1, back-to-back -> rvalid m0, m1, m0 on consecutive cycles with the correct data.
REQ-045 rst_n=0 one cycle after a read grant -> no rvalid ever appears; with CLEAR_ON_RESET=1 the clear restarts at address 0.
